// File: rtl/channel_ingress_fifo_pkg.sv
// -----------------------------------------------------------------------------
// channel_ingress_fifo_pkg
// Shared message-format definitions for the channel ingress FIFO and the router
// it feeds. A message carries its destination in the top HDR_DEST_WIDTH bits;
// an all-ones destination means broadcast.
// -----------------------------------------------------------------------------
package channel_ingress_fifo_pkg;

  localparam int MSG_WIDTH      = 64;
  localparam int HDR_DEST_WIDTH = 8;
  localparam int DEST_LSB       = MSG_WIDTH - HDR_DEST_WIDTH;

  typedef logic [MSG_WIDTH-1:0]      msg_t;
  typedef logic [HDR_DEST_WIDTH-1:0] dest_t;

  localparam dest_t BCAST_DEST = '1;

  function automatic dest_t get_dest(input msg_t msg);
    return msg[DEST_LSB +: HDR_DEST_WIDTH];
  endfunction

endpackage

// File: rtl/channel_ingress_fifo_if.sv
// -----------------------------------------------------------------------------
// channel_ingress_fifo_if
// Valid/ready message stream. The master drives data/valid and samples ready;
// the slave samples data/valid and drives ready.
//   data  : WIDTH-bit message
//   valid : message present
//   ready : receiver accepts this cycle
// -----------------------------------------------------------------------------
interface channel_ingress_fifo_if #(
  parameter int WIDTH = 64
) ();

  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/channel_fifo_mem.sv
// -----------------------------------------------------------------------------
// channel_fifo_mem
// DEPTH x WIDTH register array, one synchronous write port and one
// asynchronous read port (gives first-word-fall-through at the FIFO head).
//   clk     : write clock
//   wr_en   : write strobe
//   wr_addr : write index
//   wr_data : write data
//   rd_addr : read index
//   rd_data : combinational read data
// -----------------------------------------------------------------------------
module channel_fifo_mem #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: storage has no reset; the occupancy count decides what is valid, so
  // clearing the array would only cost a reset net to every bit.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/channel_ingress_fifo.sv
// -----------------------------------------------------------------------------
// channel_ingress_fifo
// Per-channel elastic buffer upstream of one router input port. Presents
// first-word-fall-through messages on a valid/ready stream.
//
// Optional build macro CHANNEL_INGRESS_DEST_CHECK_EN: messages whose
// destination is neither a legal port (0..NUM_CHANNELS-1) nor broadcast are
// accepted and silently discarded, reported via drop_pulse/drop_count.
// Without the macro every accepted message is stored and the drop outputs
// are tied to zero.
//
// Ports:
//   clk         : clock, all state on rising edge
//   reset       : asynchronous active-low reset
//   in_if       : upstream stream (slave)   - in_data/in_valid/in_ready
//   out_if      : router stream (master)    - out_data/out_valid/out_ready
//   count       : current occupancy
//   almost_full : count >= AFULL_THRESH
//   drop_pulse  : one-cycle pulse per discarded message
//   drop_count  : saturating count of discarded messages
// -----------------------------------------------------------------------------
module channel_ingress_fifo
  import channel_ingress_fifo_pkg::*;
#(
  parameter  int CHANNEL_WIDTH = MSG_WIDTH,
  parameter  int DEST_WIDTH    = HDR_DEST_WIDTH,
  parameter  int NUM_CHANNELS  = 2,
  parameter  int DEPTH         = 8,
  parameter  int AFULL_THRESH  = 6,
  localparam int AW            = $clog2(DEPTH),
  localparam int CW            = AW + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  channel_ingress_fifo_if.slave  in_if,
  channel_ingress_fifo_if.master out_if,
  output logic [CW-1:0]          count,
  output logic                   almost_full,
  output logic                   drop_pulse,
  output logic [15:0]            drop_count
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_THRESH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_next;
  logic          in_ready_q;
  logic          push;
  logic          pop;
  logic          store;

  assign in_if.ready  = in_ready_q;
  assign out_if.valid = (count != '0);

  assign push = in_if.valid && in_ready_q;
  assign pop  = out_if.valid && out_if.ready;

`ifdef CHANNEL_INGRESS_DEST_CHECK_EN
  localparam logic [DEST_WIDTH-1:0] NUM_CH_C = DEST_WIDTH'(NUM_CHANNELS);

  logic [DEST_WIDTH-1:0] dest;
  logic                  unroutable;

  assign dest       = in_if.data[CHANNEL_WIDTH-1 -: DEST_WIDTH];
  assign unroutable = (dest >= NUM_CH_C) && (dest != {DEST_WIDTH{1'b1}});
  // Unroutable messages still complete the handshake so the source never
  // stalls on them; they just never reach storage.
  assign store      = push && !unroutable;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_pulse <= 1'b0;
      drop_count <= '0;
    end else begin
      drop_pulse <= push && unroutable;
      if (push && unroutable && (drop_count != 16'hFFFF))
        drop_count <= drop_count + 16'd1;
    end
  end
`else
  assign store      = push;
  assign drop_pulse = 1'b0;
  assign drop_count = '0;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    count_next = count;
    if (store && !pop)      count_next = count + CW'(1);
    else if (!store && pop) count_next = count - CW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      in_ready_q  <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      if (store) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      count       <= count_next;
      // Registered from count_next: no combinational path from out_ready,
      // and a full FIFO only reopens the cycle after a pop.
      in_ready_q  <= (count_next < DEPTH_C);
      almost_full <= (count_next >= AFULL_C);
    end
  end

  channel_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (CHANNEL_WIDTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (store),
    .wr_addr (wr_ptr),
    .wr_data (in_if.data),
    .rd_addr (rd_ptr),
    .rd_data (out_if.data)
  );

endmodule

// File: tb/tb_channel_ingress_fifo.sv
// -----------------------------------------------------------------------------
// tb_channel_ingress_fifo
// Scoreboard bench: stored messages are queued when accepted and compared in
// order as the DUT pops them. Inputs are driven and outputs observed at the
// falling edge.
// -----------------------------------------------------------------------------
module tb_channel_ingress_fifo;
  import channel_ingress_fifo_pkg::*;

  localparam int DEPTH = 8;
  localparam int AFULL = 6;
  localparam int NCH   = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  channel_ingress_fifo_if #(.WIDTH(MSG_WIDTH)) in_bus ();
  channel_ingress_fifo_if #(.WIDTH(MSG_WIDTH)) out_bus ();

  logic [CW-1:0] count;
  logic          almost_full;
  logic          drop_pulse;
  logic [15:0]   drop_count;

  channel_ingress_fifo #(
    .CHANNEL_WIDTH (MSG_WIDTH),
    .DEST_WIDTH    (HDR_DEST_WIDTH),
    .NUM_CHANNELS  (NCH),
    .DEPTH         (DEPTH),
    .AFULL_THRESH  (AFULL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_if       (in_bus),
    .out_if      (out_bus),
    .count       (count),
    .almost_full (almost_full),
    .drop_pulse  (drop_pulse),
    .drop_count  (drop_count)
  );

  int   checks   = 0;
  int   failures = 0;
  msg_t sb[$];

  // Bench-side model of the control state.
  int         m_count;
  logic       m_in_ready;
  logic [2:0] m_wr_ptr;
  logic       m_drop;

  function automatic logic model_stores(input msg_t d);
`ifdef CHANNEL_INGRESS_DEST_CHECK_EN
    logic [7:0] dst;
    dst = d[63:56];
    return !((dst >= 8'(NCH)) && (dst != 8'hFF));
`else
    return 1'b1;
`endif
  endfunction

  function automatic msg_t rand_msg();
    msg_t m;
    m = {$urandom, $urandom};
    m[63:56] = 8'($urandom_range(0, NCH - 1));
    return m;
  endfunction

  // One clock: drive at a falling edge, capture the pre-edge head, step the
  // model across the rising edge, return at the next falling edge.
  task automatic cycle(input logic v, input msg_t d, input logic r,
                       output logic acc, output logic pp, output msg_t pd);
    logic st;
    in_bus.valid  = v;
    in_bus.data   = d;
    out_bus.ready = r;
    pd  = out_bus.data;
    acc = v && m_in_ready;
    st  = acc && model_stores(d);
    pp  = r && (m_count != 0);
    @(posedge clk);
    @(negedge clk);
    if (st) begin
      sb.push_back(d);
      m_wr_ptr = m_wr_ptr + 3'd1;
    end
    m_drop     = acc && !st;
    m_count    = m_count + (st ? 1 : 0) - (pp ? 1 : 0);
    m_in_ready = (m_count < DEPTH);
    in_bus.valid  = 1'b0;
    out_bus.ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset         = 1'b0;
    in_bus.valid  = 1'b0;
    in_bus.data   = '0;
    out_bus.ready = 1'b0;
    m_count = 0; m_in_ready = 1'b0; m_wr_ptr = '0; m_drop = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic acc, pp; msg_t pd;
    @(negedge clk);
    reset = 1'b0;
    in_bus.valid = 1'b0; in_bus.data = '0; out_bus.ready = 1'b0;
    m_count = 0; m_in_ready = 1'b0; m_wr_ptr = '0; m_drop = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_bus.valid, in_bus.ready, almost_full, drop_pulse} !== 4'b0000 ||
        count !== '0 || drop_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_state got valid=%b ready=%b af=%b dp=%b count=%0d dc=%0d exp all zero",
               out_bus.valid, in_bus.ready, almost_full, drop_pulse, count, drop_count);
    end
    reset = 1'b1;
    checks++;
    if (in_bus.ready !== 1'b0) begin
      failures++; $display("FAIL ready_at_release got=%b exp=0", in_bus.ready);
    end
    cycle(1'b0, '0, 1'b0, acc, pp, pd);
    checks++;
    if (in_bus.ready !== 1'b1) begin
      failures++; $display("FAIL ready_after_release got=%b exp=1", in_bus.ready);
    end
  endtask

  task automatic test_single_stall();
    logic acc, pp; msg_t pd, exp;
    msg_t first;
    first = 64'h01_00000000000A5;
    cycle(1'b1, first, 1'b0, acc, pp, pd);
    checks++;
    if (out_bus.valid !== 1'b1 || count !== CW'(1)) begin
      failures++; $display("FAIL single_push got valid=%b count=%0d exp valid=1 count=1", out_bus.valid, count);
    end
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, '0, 1'b0, acc, pp, pd);
      checks++;
      if (out_bus.valid !== 1'b1 || out_bus.data !== first) begin
        failures++; $display("FAIL stall_hold[%0d] got valid=%b data=%h exp 1 %h", i, out_bus.valid, out_bus.data, first);
      end
    end
    cycle(1'b0, '0, 1'b1, acc, pp, pd);
    if (pp) begin
      exp = sb.pop_front(); checks++;
      if (pd !== exp) begin failures++; $display("FAIL single_pop got=%h exp=%h", pd, exp); end
    end
    checks++;
    if (out_bus.valid !== 1'b0) begin
      failures++; $display("FAIL single_empty got valid=%b exp=0", out_bus.valid);
    end
  endtask

  task automatic test_fill();
    logic acc, pp; msg_t pd;
    do_reset();
    cycle(1'b0, '0, 1'b0, acc, pp, pd);
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1'b1, rand_msg(), 1'b0, acc, pp, pd);
      checks++;
      if (count !== CW'(m_count) || almost_full !== (m_count >= AFULL) ||
          in_bus.ready !== (m_count < DEPTH)) begin
        failures++;
        $display("FAIL fill[%0d] got count=%0d af=%b ready=%b exp count=%0d af=%b ready=%b",
                 i, count, almost_full, in_bus.ready, m_count, m_count >= AFULL, m_count < DEPTH);
      end
    end
    cycle(1'b1, rand_msg(), 1'b0, acc, pp, pd);
    checks++;
    if (acc !== 1'b0 || count !== CW'(DEPTH) || in_bus.ready !== 1'b0) begin
      failures++; $display("FAIL full_reject got count=%0d ready=%b exp count=%0d ready=0", count, in_bus.ready, DEPTH);
    end
  endtask

  task automatic test_wrap_order();
    logic acc, pp; msg_t pd, exp;
    int sent;
    cycle(1'b0, '0, 1'b1, acc, pp, pd);
    if (pp) begin
      exp = sb.pop_front(); checks++;
      if (pd !== exp) begin failures++; $display("FAIL full_pop got=%h exp=%h", pd, exp); end
    end
    checks++;
    if (in_bus.ready !== 1'b1 || count !== CW'(DEPTH - 1)) begin
      failures++; $display("FAIL reopen got ready=%b count=%0d exp 1 %0d", in_bus.ready, count, DEPTH - 1);
    end
    checks++;
    if (dut.wr_ptr !== m_wr_ptr) begin
      failures++; $display("FAIL wrap_ptr got=%0d exp=%0d", dut.wr_ptr, m_wr_ptr);
    end
    sent = 0;
    for (int k = 0; k < 300 && (sent < 20 || m_count != 0); k++) begin
      cycle(sent < 20 && $urandom_range(0, 3) != 0, rand_msg(), 1'($urandom_range(0, 1)), acc, pp, pd);
      if (acc) sent++;
      if (pp) begin
        exp = sb.pop_front(); checks++;
        if (pd !== exp) begin failures++; $display("FAIL wrap_order got=%h exp=%h", pd, exp); end
      end
    end
    checks++;
    if (sent != 20 || m_count != 0 || out_bus.valid !== 1'b0) begin
      failures++; $display("FAIL wrap_drain got sent=%0d left=%0d valid=%b exp 20 0 0", sent, m_count, out_bus.valid);
    end
  endtask

  task automatic test_back_to_back();
    logic acc, pp; msg_t pd, exp;
    for (int i = 0; i < 3; i++) cycle(1'b1, rand_msg(), 1'b0, acc, pp, pd);
    for (int i = 0; i < 50; i++) begin
      cycle(1'b1, rand_msg(), 1'b1, acc, pp, pd);
      if (pp) begin
        exp = sb.pop_front(); checks++;
        if (pd !== exp) begin failures++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, pd, exp); end
      end
      checks++;
      if (count !== CW'(3)) begin
        failures++; $display("FAIL b2b_count[%0d] got=%0d exp=3", i, count);
      end
    end
    for (int k = 0; k < DEPTH + 4 && m_count != 0; k++) begin
      cycle(1'b0, '0, 1'b1, acc, pp, pd);
      if (pp) begin
        exp = sb.pop_front(); checks++;
        if (pd !== exp) begin failures++; $display("FAIL b2b_drain got=%h exp=%h", pd, exp); end
      end
    end
  endtask

  task automatic test_dest_check();
    logic acc, pp; msg_t pd, exp;
    msg_t msgs[3];
    int   exp_count, exp_drops, pulses;
`ifdef CHANNEL_INGRESS_DEST_CHECK_EN
    exp_count = 2; exp_drops = 1;
`else
    exp_count = 3; exp_drops = 0;
`endif
    msgs[0] = {8'h05, 56'h11_2233_4455_6677};
    msgs[1] = {8'hFF, 56'h88_99AA_BBCC_DDEE};
    msgs[2] = {8'h01, 56'h01_0203_0405_0607};
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(i < 3, (i < 3) ? msgs[i] : '0, 1'b0, acc, pp, pd);
      if (drop_pulse === 1'b1) pulses++;
      checks++;
      if (drop_pulse !== m_drop) begin
        failures++; $display("FAIL drop_pulse[%0d] got=%b exp=%b", i, drop_pulse, m_drop);
      end
    end
    checks++;
    if (count !== CW'(exp_count) || drop_count !== 16'(exp_drops) || pulses != exp_drops) begin
      failures++;
      $display("FAIL dest_check got count=%0d dc=%0d pulses=%0d exp %0d %0d %0d",
               count, drop_count, pulses, exp_count, exp_drops, exp_drops);
    end
    for (int k = 0; k < DEPTH + 4 && m_count != 0; k++) begin
      cycle(1'b0, '0, 1'b1, acc, pp, pd);
      if (pp) begin
        exp = sb.pop_front(); checks++;
        if (pd !== exp) begin failures++; $display("FAIL dest_drain got=%h exp=%h", pd, exp); end
      end
    end
  endtask

  task automatic test_mid_reset();
    logic acc, pp; msg_t pd, exp;
    msg_t fresh;
    for (int i = 0; i < 4; i++) cycle(1'b1, rand_msg(), 1'b0, acc, pp, pd);
    checks++;
    if (count !== CW'(4)) begin failures++; $display("FAIL pre_reset_count got=%0d exp=4", count); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (out_bus.valid !== 1'b0 || in_bus.ready !== 1'b0 || count !== '0) begin
      failures++; $display("FAIL async_reset got valid=%b ready=%b count=%0d exp 0 0 0", out_bus.valid, in_bus.ready, count);
    end
    m_count = 0; m_in_ready = 1'b0; m_wr_ptr = '0; sb.delete();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, '0, 1'b1, acc, pp, pd);
      checks++;
      if (out_bus.valid !== 1'b0) begin failures++; $display("FAIL post_reset_idle[%0d] got valid=%b exp=0", i, out_bus.valid); end
    end
    fresh = rand_msg();
    cycle(1'b1, fresh, 1'b0, acc, pp, pd);
    checks++;
    if (out_bus.valid !== 1'b1 || out_bus.data !== fresh || count !== CW'(1)) begin
      failures++; $display("FAIL post_reset_push got valid=%b data=%h count=%0d exp 1 %h 1", out_bus.valid, out_bus.data, count, fresh);
    end
    cycle(1'b0, '0, 1'b1, acc, pp, pd);
    if (pp) begin
      exp = sb.pop_front(); checks++;
      if (pd !== exp) begin failures++; $display("FAIL post_reset_pop got=%h exp=%h", pd, exp); end
    end
  endtask

  initial begin
    in_bus.valid  = 1'b0;
    in_bus.data   = '0;
    out_bus.ready = 1'b0;
    test_reset();
    test_single_stall();
    test_fill();
    test_wrap_order();
    test_back_to_back();
    test_dest_check();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
